// File: rtl/alu_seq_if.sv
// Request/response bundle between the decode stage and the alu_seq unit.
interface alu_seq_if #(
    parameter int WIDTH = 32
);
    logic             valid_i;
    logic             ready_o;
    logic [3:0]       ctrl_i;
    logic [WIDTH-1:0] src1_i;
    logic [WIDTH-1:0] src2_i;
    logic             valid_o;
    logic [WIDTH-1:0] result_o;
    logic             zero_o;
    logic             cout_o;
    logic             overflow_o;
    logic             illegal_o;

    modport master (
        output valid_i, ctrl_i, src1_i, src2_i,
        input  ready_o, valid_o, result_o, zero_o, cout_o, overflow_o, illegal_o
    );

    modport slave (
        input  valid_i, ctrl_i, src1_i, src2_i,
        output ready_o, valid_o, result_o, zero_o, cout_o, overflow_o, illegal_o
    );
endinterface

// File: rtl/alu_seq.sv
// Registered WIDTH-bit ALU with valid/ready request handshake and registered flags.
// Defining ALU_SEQ_MUL_EN adds the multi-cycle unsigned shift-add multiplier (ctrl 1000).
module alu_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input logic      clk_i,
    input logic      rst_i,
    alu_seq_if.slave bus
);
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;

    logic [WIDTH:0]   add_sum_s;
    logic [WIDTH:0]   sub_sum_s;
    logic             add_ovf_s;
    logic             sub_ovf_s;
    logic [WIDTH-1:0] res_s;
    logic             zero_s;
    logic             cout_s;
    logic             ovf_s;
    logic             ill_s;
    logic             ready_s;
    logic             accept_s;

    logic [WIDTH-1:0] result_r;
    logic             zero_r;
    logic             cout_r;
    logic             ovf_r;
    logic             illegal_r;
    logic             valid_r;

`ifdef ALU_SEQ_MUL_EN
    localparam logic [3:0] OP_MUL = 4'b1000;

    typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t             state_r;
    logic               is_mul_s;
    logic [WIDTH-1:0]   mcand_r;
    logic [WIDTH-1:0]   mplier_r;
    logic [2*WIDTH-1:0] acc_r;
    logic [2*WIDTH-1:0] acc_next_s;
    logic [WIDTH:0]     mul_sum_s;
    logic [CNT_W-1:0]   cnt_r;

    assign ready_s = (state_r == IDLE) & ~rst_i;

    // One shift-add step: add multiplicand into the upper half, then shift right one place
    always_comb begin
        if (mplier_r[0]) begin
            mul_sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + {1'b0, mcand_r};
        end else begin
            mul_sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]};
        end
        acc_next_s = {mul_sum_s, acc_r[WIDTH-1:1]};
    end
`else
    assign ready_s = ~rst_i;
`endif

    assign accept_s = bus.valid_i & ready_s;

    // Shared adder paths; SUB and SLT both use A + ~B + 1
    always_comb begin
        add_sum_s = {1'b0, bus.src1_i} + {1'b0, bus.src2_i};
        sub_sum_s = {1'b0, bus.src1_i} + {1'b0, ~bus.src2_i} + {{WIDTH{1'b0}}, 1'b1};
        add_ovf_s = (bus.src1_i[WIDTH-1] == bus.src2_i[WIDTH-1]) &
                    (add_sum_s[WIDTH-1] != bus.src1_i[WIDTH-1]);
        sub_ovf_s = (bus.src1_i[WIDTH-1] != bus.src2_i[WIDTH-1]) &
                    (sub_sum_s[WIDTH-1] != bus.src1_i[WIDTH-1]);
    end

    // Single-cycle result and flag decode
    always_comb begin
        res_s  = {WIDTH{1'b0}};
        cout_s = 1'b0;
        ovf_s  = 1'b0;
        ill_s  = 1'b0;
`ifdef ALU_SEQ_MUL_EN
        is_mul_s = 1'b0;
`endif
        case (bus.ctrl_i)
            OP_AND: res_s = bus.src1_i & bus.src2_i;
            OP_OR:  res_s = bus.src1_i | bus.src2_i;
            OP_NOR: res_s = ~(bus.src1_i | bus.src2_i);
            OP_ADD: begin
                res_s  = add_sum_s[WIDTH-1:0];
                cout_s = add_sum_s[WIDTH];
                ovf_s  = add_ovf_s;
            end
            OP_SUB: begin
                res_s  = sub_sum_s[WIDTH-1:0];
                cout_s = sub_sum_s[WIDTH];
                ovf_s  = sub_ovf_s;
            end
            OP_SLT: res_s = {{(WIDTH-1){1'b0}}, sub_sum_s[WIDTH-1] ^ sub_ovf_s};
`ifdef ALU_SEQ_MUL_EN
            OP_MUL: is_mul_s = 1'b1;
`endif
            default: ill_s = 1'b1;
        endcase
        zero_s = (res_s == {WIDTH{1'b0}});
    end

    // Request acceptance, result/flag registers and multiplier sequencing
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            result_r  <= {WIDTH{1'b0}};
            zero_r    <= 1'b0;
            cout_r    <= 1'b0;
            ovf_r     <= 1'b0;
            illegal_r <= 1'b0;
            valid_r   <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            state_r   <= IDLE;
            mcand_r   <= {WIDTH{1'b0}};
            mplier_r  <= {WIDTH{1'b0}};
            acc_r     <= {(2*WIDTH){1'b0}};
            cnt_r     <= {CNT_W{1'b0}};
`endif
        end else begin
            valid_r <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            case (state_r)
                IDLE: begin
                    if (accept_s && is_mul_s) begin
                        mcand_r  <= bus.src1_i;
                        mplier_r <= bus.src2_i;
                        acc_r    <= {(2*WIDTH){1'b0}};
                        cnt_r    <= CNT_W'(WIDTH - 1);
                        state_r  <= RUN;
                    end else if (accept_s) begin
                        result_r  <= res_s;
                        zero_r    <= zero_s;
                        cout_r    <= cout_s;
                        ovf_r     <= ovf_s;
                        illegal_r <= ill_s;
                        valid_r   <= 1'b1;
                    end
                end
                RUN: begin
                    acc_r    <= acc_next_s;
                    mplier_r <= mplier_r >> 1;
                    if (cnt_r == {CNT_W{1'b0}}) begin
                        result_r  <= acc_next_s[WIDTH-1:0];
                        zero_r    <= (acc_next_s[WIDTH-1:0] == {WIDTH{1'b0}});
                        cout_r    <= 1'b0;
                        ovf_r     <= |acc_next_s[2*WIDTH-1:WIDTH];
                        illegal_r <= 1'b0;
                        valid_r   <= 1'b1;
                        state_r   <= IDLE;
                    end else begin
                        cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                default: state_r <= IDLE;
            endcase
`else
            if (accept_s) begin
                result_r  <= res_s;
                zero_r    <= zero_s;
                cout_r    <= cout_s;
                ovf_r     <= ovf_s;
                illegal_r <= ill_s;
                valid_r   <= 1'b1;
            end
`endif
        end
    end

    assign bus.ready_o    = ready_s;
    assign bus.valid_o    = valid_r;
    assign bus.result_o   = result_r;
    assign bus.zero_o     = zero_r;
    assign bus.cout_o     = cout_r;
    assign bus.overflow_o = ovf_r;
    assign bus.illegal_o  = illegal_r;
endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq; MUL scenarios run when ALU_SEQ_MUL_EN is defined.
module tb_alu_seq;
    localparam int WIDTH = 32;
    localparam logic [3:0] C_AND = 4'b0000;
    localparam logic [3:0] C_OR  = 4'b0001;
    localparam logic [3:0] C_ADD = 4'b0010;
    localparam logic [3:0] C_SUB = 4'b0110;
    localparam logic [3:0] C_SLT = 4'b0111;
    localparam logic [3:0] C_NOR = 4'b1100;
    localparam logic [3:0] C_MUL = 4'b1000;

    typedef struct packed {
        logic [3:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [4:0]  fl;   // {valid, zero, cout, overflow, illegal}
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    alu_seq_if #(.WIDTH(WIDTH)) bus ();

    alu_seq #(.WIDTH(WIDTH)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    function automatic logic [4:0] flags();
        return {bus.valid_o, bus.zero_o, bus.cout_o, bus.overflow_o, bus.illegal_o};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        bus.valid_i = v;
        bus.ctrl_i  = c;
        bus.src1_i  = a;
        bus.src2_i  = b;
    endtask

    // Steps until valid_o (bounded); k = edges after acceptance, lowc = cycles with ready_o low
    task automatic wait_result(input bit noise, output int k, output int lowc);
        k    = 0;
        lowc = (bus.ready_o == 1'b0) ? 1 : 0;
        for (int i = 1; i <= 64 && k == 0; i++) begin
            if (noise) drive(1'b1, C_ADD, 32'(i), ~32'(i));
            step();
            if (bus.valid_o === 1'b1) k = i;
            else if (bus.ready_o === 1'b0) lowc++;
        end
        drive(1'b0, C_AND, 32'h0, 32'h0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, C_AND, 32'h0, 32'h0);
        step();
        step();
        n_cmp++; if (bus.ready_o !== 1'b0) begin n_bad++; $display("FAIL reset_ready: got %b want 0", bus.ready_o); end
        n_cmp++; if (bus.result_o !== 32'h0) begin n_bad++; $display("FAIL reset_result: got %h want 0", bus.result_o); end
        n_cmp++; if (flags() !== 5'b00000) begin n_bad++; $display("FAIL reset_flags: got %b want 00000", flags()); end
        rst = 1'b0;
        #1;
        n_cmp++; if (bus.ready_o !== 1'b1) begin n_bad++; $display("FAIL reset_release_ready: got %b want 1", bus.ready_o); end
    endtask

    task automatic test_single_cycle();
        vec_t v [0:9];
        v = '{
            '{C_ADD, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 5'b10010},
            '{C_ADD, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 5'b11100},
            '{C_SUB, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 5'b10110},
            '{C_SUB, 32'h00000003, 32'h00000005, 32'hFFFFFFFE, 5'b10000},
            '{C_AND, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 5'b10000},
            '{C_OR,  32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 5'b10000},
            '{C_NOR, 32'hF0F0F0F0, 32'hFF00FF00, 32'h000F000F, 5'b10000},
            '{C_SLT, 32'h80000000, 32'h7FFFFFFF, 32'h00000001, 5'b10000},
            '{C_SLT, 32'h00000005, 32'h00000003, 32'h00000000, 5'b11000},
            '{C_AND, 32'h12345678, 32'h00000000, 32'h00000000, 5'b11000}
        };
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, v[i].ctrl, v[i].a, v[i].b);
            step();
            drive(1'b0, C_AND, 32'h0, 32'h0);
            n_cmp++; if (bus.result_o !== v[i].res) begin n_bad++; $display("FAIL op%0d_result: got %h want %h", i, bus.result_o, v[i].res); end
            n_cmp++; if (flags() !== v[i].fl) begin n_bad++; $display("FAIL op%0d_flags: got %b want %b", i, flags(), v[i].fl); end
            step();
            n_cmp++; if (bus.valid_o !== 1'b0) begin n_bad++; $display("FAIL op%0d_valid_drop: got %b want 0", i, bus.valid_o); end
            n_cmp++; if (bus.result_o !== v[i].res) begin n_bad++; $display("FAIL op%0d_hold: got %h want %h", i, bus.result_o, v[i].res); end
        end
    endtask

    task automatic test_back_to_back();
        drive(1'b1, C_SUB, 32'h5, 32'h5);
        step();
        n_cmp++; if (bus.result_o !== 32'h0) begin n_bad++; $display("FAIL b2b_sub_result: got %h want 0", bus.result_o); end
        n_cmp++; if (flags() !== 5'b11100) begin n_bad++; $display("FAIL b2b_sub_flags: got %b want 11100", flags()); end
        n_cmp++; if (bus.ready_o !== 1'b1) begin n_bad++; $display("FAIL b2b_ready: got %b want 1", bus.ready_o); end
        drive(1'b1, C_SLT, 32'hFFFFFFFF, 32'h00000001);
        step();
        drive(1'b0, C_AND, 32'h0, 32'h0);
        n_cmp++; if (bus.result_o !== 32'h1) begin n_bad++; $display("FAIL b2b_slt_result: got %h want 1", bus.result_o); end
        n_cmp++; if (flags() !== 5'b10000) begin n_bad++; $display("FAIL b2b_slt_flags: got %b want 10000", flags()); end
        step();
    endtask

    task automatic test_illegal();
        drive(1'b1, 4'b1111, 32'h3, 32'h4);
        step();
        drive(1'b0, C_AND, 32'h0, 32'h0);
        n_cmp++; if (bus.result_o !== 32'h0) begin n_bad++; $display("FAIL ill_result: got %h want 0", bus.result_o); end
        n_cmp++; if (flags() !== 5'b11001) begin n_bad++; $display("FAIL ill_flags: got %b want 11001", flags()); end
        step();
`ifndef ALU_SEQ_MUL_EN
        drive(1'b1, C_ADD, 32'h1, 32'h1);
        step();
        drive(1'b1, C_MUL, 32'h3, 32'h4);
        step();
        drive(1'b0, C_AND, 32'h0, 32'h0);
        n_cmp++; if (bus.result_o !== 32'h0) begin n_bad++; $display("FAIL mul_off_result: got %h want 0", bus.result_o); end
        n_cmp++; if (flags() !== 5'b11001) begin n_bad++; $display("FAIL mul_off_flags: got %b want 11001", flags()); end
        n_cmp++; if (bus.ready_o !== 1'b1) begin n_bad++; $display("FAIL mul_off_ready: got %b want 1", bus.ready_o); end
        step();
`endif
    endtask

`ifdef ALU_SEQ_MUL_EN
    task automatic test_mul();
        int k;
        int lowc;
        drive(1'b1, C_MUL, 32'h00010000, 32'h00010000);
        step();
        drive(1'b0, C_AND, 32'h0, 32'h0);
        wait_result(1'b0, k, lowc);
        n_cmp++; if (k != 32) begin n_bad++; $display("FAIL mul1_latency: got %0d want 32", k); end
        n_cmp++; if (lowc != 32) begin n_bad++; $display("FAIL mul1_ready_low: got %0d want 32", lowc); end
        n_cmp++; if (bus.ready_o !== 1'b1) begin n_bad++; $display("FAIL mul1_ready_back: got %b want 1", bus.ready_o); end
        n_cmp++; if (bus.result_o !== 32'h0) begin n_bad++; $display("FAIL mul1_result: got %h want 0", bus.result_o); end
        n_cmp++; if (flags() !== 5'b11010) begin n_bad++; $display("FAIL mul1_flags: got %b want 11010", flags()); end
        step();
        n_cmp++; if (bus.valid_o !== 1'b0) begin n_bad++; $display("FAIL mul1_valid_drop: got %b want 0", bus.valid_o); end
        drive(1'b1, C_MUL, 32'h7, 32'h6);
        step();
        drive(1'b0, C_AND, 32'h0, 32'h0);
        wait_result(1'b0, k, lowc);
        n_cmp++; if (k != 32) begin n_bad++; $display("FAIL mul2_latency: got %0d want 32", k); end
        n_cmp++; if (bus.result_o !== 32'd42) begin n_bad++; $display("FAIL mul2_result: got %h want 2a", bus.result_o); end
        n_cmp++; if (flags() !== 5'b10000) begin n_bad++; $display("FAIL mul2_flags: got %b want 10000", flags()); end
        step();
    endtask

    task automatic test_mul_ignore();
        int k;
        int lowc;
        drive(1'b1, C_MUL, 32'h12345678, 32'h00000010);
        step();
        wait_result(1'b1, k, lowc);
        n_cmp++; if (k != 32) begin n_bad++; $display("FAIL ign_latency: got %0d want 32", k); end
        n_cmp++; if (bus.result_o !== 32'h23456780) begin n_bad++; $display("FAIL ign_result: got %h want 23456780", bus.result_o); end
        n_cmp++; if (flags() !== 5'b10010) begin n_bad++; $display("FAIL ign_flags: got %b want 10010", flags()); end
        step();
        n_cmp++; if (bus.valid_o !== 1'b0) begin n_bad++; $display("FAIL ign_no_extra: got %b want 0", bus.valid_o); end
        n_cmp++; if (bus.result_o !== 32'h23456780) begin n_bad++; $display("FAIL ign_hold: got %h want 23456780", bus.result_o); end
    endtask
`endif

    task automatic test_reset_abort();
        int pulses;
`ifdef ALU_SEQ_MUL_EN
        drive(1'b1, C_MUL, 32'h5, 32'h5);
        step();
        drive(1'b0, C_AND, 32'h0, 32'h0);
        repeat (9) step();
`else
        drive(1'b1, C_ADD, 32'h1, 32'h2);
        step();
        drive(1'b0, C_AND, 32'h0, 32'h0);
        step();
`endif
        rst = 1'b1;
        step();
        n_cmp++; if (bus.result_o !== 32'h0) begin n_bad++; $display("FAIL abort_result: got %h want 0", bus.result_o); end
        n_cmp++; if (flags() !== 5'b00000) begin n_bad++; $display("FAIL abort_flags: got %b want 00000", flags()); end
        n_cmp++; if (bus.ready_o !== 1'b0) begin n_bad++; $display("FAIL abort_ready: got %b want 0", bus.ready_o); end
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (bus.valid_o !== 1'b0) pulses++;
        end
        n_cmp++; if (pulses != 0) begin n_bad++; $display("FAIL abort_no_valid: got %0d pulses want 0", pulses); end
        drive(1'b1, C_ADD, 32'h2, 32'h3);
        step();
        drive(1'b0, C_AND, 32'h0, 32'h0);
        n_cmp++; if (bus.result_o !== 32'h5) begin n_bad++; $display("FAIL abort_add_result: got %h want 5", bus.result_o); end
        n_cmp++; if (flags() !== 5'b10000) begin n_bad++; $display("FAIL abort_add_flags: got %b want 10000", flags()); end
        step();
    endtask

    initial begin
        drive(1'b0, C_AND, 32'h0, 32'h0);
        test_reset();
        test_single_cycle();
        test_back_to_back();
        test_illegal();
`ifdef ALU_SEQ_MUL_EN
        test_mul();
        test_mul_ignore();
`endif
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
